shift_left_logical_seq: RTL and testbench

- Multi-cycle logical left shifter; the opposite direction of the team's combinational right shifter.
- Intended for the ALU/datapath where a small-area shifter is traded for latency.
- Uses a log-stage iterative structure: one shamt bit is applied per cycle (shift by 2^k when shamt[k]=1), with zero fill from the LSB.
- Uses a valid/ready handshake on both the input and output sides.

---
 rtl/shift_left_logical_seq_if.sv | 31 +++
 rtl/shift_left_logical_seq.sv | 92 +++++++++
 tb/tb_shift_left_logical_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/shift_left_logical_seq_if.sv
// Handshake bundle for shift_left_logical_seq.
//   in, shamt, in_valid : operand, shift amount and request strobe (producer -> shifter)
//   in_ready            : shifter can take an operand
//   out, out_valid      : result and result strobe (shifter -> consumer)
//   out_ready           : consumer takes the result
//   busy                : shifter is working on or holding an operation
// The shifter connects to modport slave, the driving side to modport master.
interface shift_left_logical_seq_if #(
  parameter int N = 32
);
  localparam int L = $clog2(N);

  logic [N-1:0] in;
  logic [L-1:0] shamt;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport slave (
    input  in, shamt, in_valid, out_ready,
    output in_ready, out, out_valid, busy
  );

  modport master (
    output in, shamt, in_valid, out_ready,
    input  in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/shift_left_logical_seq.sv
// Multi-cycle logical left shifter. One shamt bit is applied per cycle
// (stage k shifts by 2^k when shamt[k]=1), zero fill from the LSB.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, priority over everything
//   bus  - shift_left_logical_seq_if.slave (valid/ready in and out, busy)
// Optional build macro SHIFT_LEFT_LOGICAL_EARLY_EXIT_EN: leave SHIFT as soon
// as no higher shamt bits remain set. Results are identical either way.
module shift_left_logical_seq #(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  shift_left_logical_seq_if.slave bus
);
  localparam int L  = $clog2(N);
  localparam int SW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [N-1:0]    r_acc,   w_acc_nx;
  logic [L-1:0]    r_sh,    w_sh_nx;
  logic [SW-1:0]   r_stage, w_stage_nx;
  logic [N-1:0]    r_out,   w_out_nx;

  logic [N-1:0]    w_shifted;
  logic            w_last;

  // Current stage applied to the accumulator.
  assign w_shifted = r_sh[r_stage] ? (r_acc << (1 << r_stage)) : r_acc;

`ifdef SHIFT_LEFT_LOGICAL_EARLY_EXIT_EN
  // Finish once no shamt bits above the current stage are set. shamt=0 still
  // passes through stage 0, giving the minimum one-cycle latency.
  assign w_last = (r_stage == SW'(L - 1)) || (((r_sh >> r_stage) >> 1) == '0);
`else
  assign w_last = (r_stage == SW'(L - 1));
`endif

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_sh_nx    = r_sh;
    w_stage_nx = r_stage;
    w_out_nx   = r_out;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_acc_nx   = bus.in;
          w_sh_nx    = bus.shamt;
          w_stage_nx = '0;
          w_state_nx = SHIFT;
        end
      end
      SHIFT: begin
        w_acc_nx = w_shifted;
        if (w_last) begin
          w_out_nx   = w_shifted;
          w_state_nx = DONE;
        end else begin
          w_stage_nx = r_stage + SW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_sh    <= '0;
      r_stage <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_sh    <= w_sh_nx;
      r_stage <= w_stage_nx;
      r_out   <= w_out_nx;
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out       = r_out;
endmodule

// File: tb/tb_shift_left_logical_seq.sv
module tb_shift_left_logical_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_left_logical_seq_if #(.N(32)) bus ();

  shift_left_logical_seq #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [31:0] e;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected cycles from the accept edge to out_valid.
  function automatic int exp_lat(input logic [4:0] s);
`ifdef SHIFT_LEFT_LOGICAL_EARLY_EXIT_EN
    for (int i = 4; i >= 0; i--) if (s[i]) return i + 1;
    return 1;
`else
    return 5;
`endif
  endfunction

  // Waits (bounded) for out_valid; returns edges counted after the accept edge.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Called just after a negedge. Full op with output taken once valid.
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic [31:0] e,
                        input string nm);
    int n;
    bus.in = a; bus.shamt = s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Operand churn while busy must not affect the result.
    bus.in_valid = 1'b0; bus.in = $urandom; bus.shamt = 5'($urandom);
    wait_valid(n);
    chk({nm, " latency"}, 32'(n), 32'(exp_lat(s)));
    chk({nm, " out"}, bus.out, e);
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    chk({nm, " in_ready after out hs"}, {31'd0, bus.in_ready}, 32'd1);
    chk({nm, " out_valid after out hs"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    tbl[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
    tbl[1] = '{32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0};
    tbl[2] = '{32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
    tbl[3] = '{32'h1234_5678, 5'd16, 32'h5678_0000};
    tbl[4] = '{32'h0000_0011, 5'd3,  32'h0000_0088};
    tbl[5] = '{32'hDEAD_BEEF, 5'd1,  32'hBD5B_7DDE};
    tbl[6] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    tbl[7] = '{32'h8000_0001, 5'd2,  32'h0000_0004};
    tbl[8] = '{32'h0F0F_0F0F, 5'd12, 32'hF0F0_F000};

    bus.in = '0; bus.shamt = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready during rst", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst out", bus.out, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 9; i++)
      run_op(tbl[i].a, tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

    // Backpressure: hold out_ready low for 3 cycles in DONE with a competing request
    bus.in = 32'h0000_00FF; bus.shamt = 5'd8; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("bp latency", 32'(n), 32'(exp_lat(5'd8)));
    @(negedge clk);
    bus.in = 32'h1; bus.shamt = 5'd1; bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk("bp out stable", bus.out, 32'h0000_FF00);
      chk("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    // out_ready and in_valid together in DONE: only the output handshake happens
    bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    chk("bp back to idle", {31'd0, bus.busy}, 32'd0);
    chk("bp in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;  // accepts in=1, shamt=1
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("bp next latency", 32'(n), 32'(exp_lat(5'd1)));
    chk("bp next out", bus.out, 32'h0000_0002);
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset mid-operation
    bus.in = 32'h1; bus.shamt = 5'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid rst busy", {31'd0, bus.busy}, 32'd0);
    chk("mid rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid rst out", bus.out, 32'd0);
    chk("mid rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    // Spurious out_ready while idle does nothing
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk); bus.out_ready = 1'b0;
    chk("idle out_ready busy", {31'd0, bus.busy}, 32'd0);
    run_op(32'h3, 5'd2, 32'h0000_000C, "after rst");

    // Latency corner cases (early-exit values when the macro is set)
    run_op(32'h0000_0007, 5'd0,  32'h0000_0007, "lat s0");
    run_op(32'h0000_0007, 5'd3,  32'h0000_0038, "lat s3");
    run_op(32'h0000_0007, 5'd16, 32'h0007_0000, "lat s16");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
